// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the next-PC branch predictor.
// Geometry defaults and 2-bit counter encodings.
package branch_predictor_pkg;

    localparam int BP_INDEX_BITS = 7;
    localparam int BP_TAG_BITS   = 10;
    localparam int InstAddrBus   = 32;

    typedef enum logic [1:0] {
        CtrSNT = 2'b00,
        CtrWNT = 2'b01,
        CtrWT  = 2'b10,
        CtrST  = 2'b11
    } bp_ctr_e;

endpackage

// File: rtl/bp_sat_ctr2.sv
// Next-state logic for a 2-bit saturating direction counter.
// JAL forces strong-taken; otherwise count up/down and clamp.
module bp_sat_ctr2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    input  logic       uncond_i,
    output logic [1:0] ctr_o
);

    // saturating step, unconditional jumps pin the counter high
    always_comb begin
        ctr_o = ctr_i;
        if (uncond_i) begin
            ctr_o = CtrST;
        end else if (taken_i) begin
            if (ctr_i != CtrST)
                ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CtrSNT)
                ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit BHT sharing one index.
// Zero-latency lookup on the fetch PC; training from EX.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = BP_INDEX_BITS,
    parameter int TAG_BITS   = BP_TAG_BITS,
    parameter int ADDR_W     = InstAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] if_pc_i,
    output logic              pre_jmp_status_o,
    output logic [ADDR_W-1:0] pre_jmp_target_o,
    input  logic              ex_upd_valid_i,
    input  logic [ADDR_W-1:0] ex_upd_pc_i,
    input  logic              ex_upd_taken_i,
    input  logic [ADDR_W-1:0] ex_upd_target_i,
    input  logic              ex_upd_uncond_i,
    input  logic              ex_upd_mispred_i,
    output logic [15:0]       mispred_cnt_o,
    output logic [15:0]       update_cnt_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [ADDR_W-1:0]   tgt_q [ENTRIES];
    logic [1:0]          ctr_q [ENTRIES];

    logic [INDEX_BITS-1:0] l_idx;
    logic [TAG_BITS-1:0]   l_tag;
    logic                  l_hit;

    logic [INDEX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0]   u_tag;
    logic                  u_hit;
    logic                  u_taken;
    logic                  u_we;
    logic [1:0]            u_ctr_cur;
    logic [1:0]            u_ctr_nxt;

    logic unused_pc_bits;

    assign unused_pc_bits = ^{if_pc_i[ADDR_W-1:TAG_HI+1],
                              ex_upd_pc_i[ADDR_W-1:TAG_HI+1]};

    // lookup against current array contents, no update bypass
    always_comb begin
        l_idx = if_pc_i[INDEX_BITS+1:2];
        l_tag = if_pc_i[TAG_HI:TAG_LO];
        l_hit = valid_q[l_idx]
             && (tag_q[l_idx] == l_tag)
             && (if_pc_i[1:0] == 2'b00);
        pre_jmp_status_o = l_hit && ctr_q[l_idx][1];
        pre_jmp_target_o = pre_jmp_status_o ? tgt_q[l_idx] : '0;
    end

    // decode the EX resolution into a write enable for one entry
    always_comb begin
        u_idx     = ex_upd_pc_i[INDEX_BITS+1:2];
        u_tag     = ex_upd_pc_i[TAG_HI:TAG_LO];
        u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_taken   = ex_upd_taken_i || ex_upd_uncond_i;
        u_ctr_cur = u_hit ? ctr_q[u_idx] : CtrWNT;
        u_we      = ex_upd_valid_i
                 && (ex_upd_pc_i[1:0] == 2'b00)
                 && (u_hit || u_taken);
    end

    bp_sat_ctr2 u_sat_ctr2 (
        .ctr_i    (u_ctr_cur),
        .taken_i  (u_taken),
        .uncond_i (ex_upd_uncond_i),
        .ctr_o    (u_ctr_nxt)
    );

    // valid bits and counters: async-cleared, written on update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= CtrWNT;
        end else if (u_we) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= u_ctr_nxt;
        end
    end

    // tag/target payload, qualified by valid so never cleared
    always_ff @(posedge clk) begin
        if (rst && u_we && u_taken) begin
            tgt_q[u_idx] <= ex_upd_target_i;
            if (!u_hit)
                tag_q[u_idx] <= u_tag;
        end
    end

    // saturating statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else if (ex_upd_valid_i) begin
            if (update_cnt_o != 16'hFFFF)
                update_cnt_o <= update_cnt_o + 16'd1;
            if (ex_upd_mispred_i && mispred_cnt_o != 16'hFFFF)
                mispred_cnt_o <= mispred_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor.
// Driver queues expectations; negedge monitor checks.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        st;
    logic [31:0] tgt;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_uncond;
    logic        upd_mis;
    logic [15:0] mcnt;
    logic [15:0] ucnt;

    typedef struct {
        string       name;
        logic        st;
        logic [31:0] tg;
        logic [15:0] mc;
        logic [15:0] uc;
    } exp_t;

    exp_t sb[$];

    logic        probe = 1'b0;
    logic [15:0] exp_m = '0;
    logic [15:0] exp_u = '0;
    int          n_cmp = 0;
    int          n_bad = 0;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc_i          (if_pc),
        .pre_jmp_status_o (st),
        .pre_jmp_target_o (tgt),
        .ex_upd_valid_i   (upd_valid),
        .ex_upd_pc_i      (upd_pc),
        .ex_upd_taken_i   (upd_taken),
        .ex_upd_target_i  (upd_target),
        .ex_upd_uncond_i  (upd_uncond),
        .ex_upd_mispred_i (upd_mis),
        .mispred_cnt_o    (mcnt),
        .update_cnt_o     (ucnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, exp);
        end
    endtask

    // monitor: pop one expectation per probed cycle
    always @(negedge clk) begin
        if (probe) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty got=0 want=1");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.name, "status", {31'd0, st}, {31'd0, e.st});
                chk(e.name, "target", tgt, e.tg);
                chk(e.name, "mcnt", {16'd0, mcnt}, {16'd0, e.mc});
                chk(e.name, "ucnt", {16'd0, ucnt}, {16'd0, e.uc});
            end
        end
    end

    task automatic push(input string nm, input logic es,
                        input logic [31:0] et);
        exp_t e;
        e.name = nm;
        e.st   = es;
        e.tg   = et;
        e.mc   = exp_m;
        e.uc   = exp_u;
        sb.push_back(e);
    endtask

    // one cycle: lookup lpc, optional update, expected pre-update view
    task automatic step(input string nm, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc,
                        input logic tk, input logic [31:0] utg,
                        input logic unc, input logic mis,
                        input logic es, input logic [31:0] et);
        if_pc      = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = tk;
        upd_target = utg;
        upd_uncond = unc;
        upd_mis    = mis;
        push(nm, es, et);
        probe = 1'b1;
        @(posedge clk);
        if (uv) begin
            if (exp_u != 16'hFFFF) exp_u = exp_u + 16'd1;
            if (mis && exp_m != 16'hFFFF) exp_m = exp_m + 16'd1;
        end
        #1;
        probe     = 1'b0;
        upd_valid = 1'b0;
        upd_uncond = 1'b0;
        upd_mis   = 1'b0;
    endtask

    task automatic look(input string nm, input logic [31:0] lpc,
                        input logic es, input logic [31:0] et);
        step(nm, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, es, et);
    endtask

    initial begin
        rst = 1'b0;
        if_pc = '0;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_target = '0;
        upd_uncond = 1'b0;
        upd_mis = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        look("reset", 32'h100, 1'b0, 32'h0);
        step("alloc100", 32'h100, 1, 32'h100, 1, 32'h200, 0, 1,
             1'b0, 32'h0);
        step("hit100_nt", 32'h100, 1, 32'h100, 0, 32'h0, 0, 1,
             1'b1, 32'h200);
        look("wnt100", 32'h100, 1'b0, 32'h0);

        step("t40_a", 32'h40, 1, 32'h40, 1, 32'h400, 0, 0, 1'b0, 32'h0);
        step("t40_b", 32'h40, 1, 32'h40, 1, 32'h400, 0, 0, 1'b1, 32'h400);
        step("t40_c", 32'h40, 1, 32'h40, 1, 32'h400, 0, 0, 1'b1, 32'h400);
        step("t40_d", 32'h40, 1, 32'h40, 1, 32'h400, 0, 0, 1'b1, 32'h400);
        step("nt40_a", 32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 1'b1, 32'h400);
        step("nt40_b", 32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 1'b1, 32'h400);
        step("nt40_c", 32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 1'b0, 32'h0);
        step("nt40_d", 32'h40, 1, 32'h40, 0, 32'h0, 0, 0, 1'b0, 32'h0);
        step("t40_e", 32'h40, 1, 32'h40, 1, 32'h400, 0, 0, 1'b0, 32'h0);
        look("sat40_lo", 32'h40, 1'b0, 32'h0);

        step("re100", 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 1'b0, 32'h0);
        step("alias", 32'h100, 1, 32'h300, 1, 32'h300, 0, 0,
             1'b1, 32'h200);
        look("evicted", 32'h100, 1'b0, 32'h0);
        look("alias_hit", 32'h300, 1'b1, 32'h300);

        step("same80", 32'h80, 1, 32'h80, 1, 32'h500, 0, 0, 1'b0, 32'h0);
        look("next80", 32'h80, 1'b1, 32'h500);

        step("al84", 32'h84, 1, 32'h84, 1, 32'h600, 0, 0, 1'b0, 32'h0);
        step("nt84", 32'h84, 1, 32'h84, 0, 32'h0, 0, 0, 1'b1, 32'h600);
        step("jal84", 32'h84, 1, 32'h84, 0, 32'h600, 1, 0, 1'b0, 32'h0);
        step("nt84_b", 32'h84, 1, 32'h84, 0, 32'h0, 0, 0, 1'b1, 32'h600);
        look("jal84_t", 32'h84, 1'b1, 32'h600);

        step("mis18a", 32'h188, 1, 32'h18A, 1, 32'h700, 0, 0, 1'b0, 32'h0);
        look("mis188", 32'h188, 1'b0, 32'h0);
        look("look82", 32'h82, 1'b0, 32'h0);

        // async reset while an update is on the bus
        if_pc      = 32'h80;
        upd_valid  = 1'b1;
        upd_pc     = 32'h80;
        upd_taken  = 1'b1;
        upd_target = 32'h900;
        upd_mis    = 1'b1;
        rst        = 1'b0;
        exp_m      = '0;
        exp_u      = '0;
        push("rst_async", 1'b0, 32'h0);
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe     = 1'b0;
        upd_valid = 1'b0;
        upd_mis   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        look("post_rst80", 32'h80, 1'b0, 32'h0);
        look("post_rst84", 32'h84, 1'b0, 32'h0);
        step("first_edge", 32'h80, 1, 32'h80, 1, 32'h800, 0, 1,
             1'b0, 32'h0);
        look("first_hit", 32'h80, 1'b1, 32'h800);

        upd_valid = 1'b1;
        upd_pc    = 32'h2;
        upd_taken = 1'b1;
        upd_mis   = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_mis   = 1'b0;
        exp_m     = 16'hFFFF;
        exp_u     = 16'hFFFF;
        look("cnt_sat", 32'h80, 1'b1, 32'h800);

        @(negedge clk);
        chk("sb_drain", "left", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Next-PC predictor that sits directly upstream of the PC register.
- Combinationally supplies the taken/not-taken prediction and the target for the current fetch PC.
- Learns from branch/jump resolutions reported by EX.
- Combines a direct-mapped BTB (tag + target) with a 2-bit saturating-counter BHT sharing the same index.

Parameters:
- INDEX_BITS, 7, log2 of entry count (128 entries); index = pc[INDEX_BITS+1:2]
- TAG_BITS, 10, tag width; tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
- ADDR_W, 32, instruction address width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low
- if_pc_i  input  ADDR_W  current fetch PC from the PC register
- pre_jmp_status_o  output  1  predict taken for if_pc_i
- pre_jmp_target_o  output  ADDR_W  predicted target, valid when pre_jmp_status_o=1
- ex_upd_valid_i  input  1  EX resolved a control-flow instruction this cycle
- ex_upd_pc_i  input  ADDR_W  PC of the resolved instruction
- ex_upd_taken_i  input  1  actual direction
- ex_upd_target_i  input  ADDR_W  actual target when taken
- ex_upd_uncond_i  input  1  instruction is JAL (always taken)
- ex_upd_mispred_i  input  1  EX flagged a misprediction (same event as the PC register's jump-wrong)
- mispred_cnt_o  output  16  saturating count of mispredictions
- update_cnt_o  output  16  saturating count of resolved updates

Behaviour:
- Storage per entry: valid (1), tag (TAG_BITS), target (ADDR_W), ctr (2).
- Lookup is purely combinational on if_pc_i (zero latency).
  - hit = valid[idx] && tag[idx]==tag(if_pc_i) && if_pc_i[1:0]==0.
  - pre_jmp_status_o = hit && ctr[idx][1].
  - pre_jmp_target_o = target[idx] when pre_jmp_status_o, else 0.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update at rising edge when ex_upd_valid_i=1 (u_idx/u_tag taken from ex_upd_pc_i):
  - Hit, taken: ctr = min(ctr+1, 3); target <= ex_upd_target_i.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate (overwrite): valid=1, tag=u_tag, target=ex_upd_target_i, ctr=10.
  - Miss, not taken: no write.
  - ex_upd_uncond_i=1: ctr forced to 11 regardless of prior value; taken is implied.
  - ex_upd_pc_i[1:0]!=0: update ignored; counters still increment.
- Update and lookup to the same index in the same cycle: lookup sees pre-update contents; there is no bypass. The new value is visible from the next cycle.
- Statistics:
  - update_cnt_o increments on every ex_upd_valid_i.
  - mispred_cnt_o increments when ex_upd_valid_i && ex_upd_mispred_i.
  - Both saturate at 16'hFFFF.
- Reset (rst=0, async, takes effect immediately, including mid-update):
  - All valid=0 and all ctr=01.
  - tag/target need not be cleared.
  - Counters=0.
  - Outputs therefore go to pre_jmp_status_o=0 and pre_jmp_target_o=0 without waiting for a clock edge.
- First edge after reset deassertion processes updates normally.
- No stall input: EX asserts ex_upd_valid_i at most once per resolved instruction. The PC register is responsible for ignoring predictions while stalled.

Decomposition:
- Shared defines header additions:
  - BP_INDEX_BITS, BP_TAG_BITS.
  - Counter encodings CtrSNT/CtrWNT/CtrWT/CtrST.
  - InstAddrBus reused for address ports.
- One natural sub-module: bp_sat_ctr2 (combinational next-state for the 2-bit counter given current value, taken, uncond).
- Arrays stay in branch_predictor; the valid array is separate flops so it can be async-cleared.

Test Plan:
- Reset then lookup pc=0x100 → pre_jmp_status_o=0, pre_jmp_target_o=0; counters 0.
- Update pc=0x100 taken target=0x200; next cycle lookup 0x100 → status=1, target=0x200 (ctr=10); update not-taken once → status=0 (ctr=01).
- Four taken updates at 0x40 then two not-taken → status stays 1 after the first not-taken (11→10→01 ends NT); verifies saturation at 11 and 00 after extra not-takens.
- Aliasing: allocate 0x100 → 0x200, then taken update 0x100+(1<<(INDEX_BITS+2)) → 0x300; lookup 0x100 → status=0; lookup the alias → target 0x300.
- Same-cycle update/lookup at 0x80 (first allocation) → status=0 that cycle, 1 the next; JAL update at 0x84 → ctr=11; a subsequent not-taken leaves status=1.
- Assert rst mid-stream with ex_upd_valid_i=1 → outputs 0 immediately; after release, lookup of the previously trained PC → status=0; mispred_cnt_o saturation checked by 65540 flagged updates → 16'hFFFF.
